// File: rtl/ff_prim_pkg.sv
// Shared constants and helpers for the CE/clear flip-flop pipeline.
package ff_prim_pkg;

  localparam int unsigned SRMODE_CE_OVER_LSR = 0;
  localparam int unsigned SRMODE_LSR_OVER_CE = 1;

  // Ceiling log2, never less than 1 so counters always have a bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/ff_stage.sv
// One data+valid register with clock enable, gated clear and sync reset.
module ff_stage
  import ff_prim_pkg::*;
#(
  parameter int unsigned       WIDTH      = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL  = '0,
  parameter int unsigned       SRMODE     = SRMODE_CE_OVER_LSR,
  parameter bit                CLEAR_DATA = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic             sr_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             dv_i,
  output logic [WIDTH-1:0] q_o,
  output logic             qv_o
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             clr_c;

  assign clr_c = sr_i & (ce_i | (SRMODE == SRMODE_LSR_OVER_CE));

  // Priority: reset, then clear, then enabled capture, else hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= RESET_VAL;
      valid_q <= 1'b0;
    end else if (clr_c) begin
      valid_q <= 1'b0;
      if (CLEAR_DATA) data_q <= RESET_VAL;
    end else if (ce_i) begin
      data_q  <= d_i;
      valid_q <= dv_i;
    end
  end

  assign q_o  = data_q;
  assign qv_o = valid_q;

endmodule

// File: rtl/ff_pipe_ce.sv
// Multi-stage CE/clear register pipeline with valid tracking and occupancy count.
module ff_pipe_ce
  import ff_prim_pkg::*;
#(
  parameter int unsigned       WIDTH      = 8,
  parameter int unsigned       DEPTH      = 3,
  parameter logic [WIDTH-1:0]  RESET_VAL  = '0,
  parameter int unsigned       SRMODE     = SRMODE_CE_OVER_LSR,
  parameter bit                CLEAR_DATA = 1'b1
) (
  input  logic                          CK,
  input  logic                          CD,
  input  logic                          SP,
  input  logic                          SR,
  input  logic [WIDTH-1:0]              D,
  input  logic                          DV,
  output logic [WIDTH-1:0]              Q,
  output logic                          QV,
  output logic [clog2(DEPTH+1)-1:0]     OCC
);

  localparam int unsigned OW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_w  [DEPTH+1];
  logic             valid_w [DEPTH+1];
  logic [OW-1:0]    occ_q;
  logic [OW-1:0]    occ_d;
  logic             clr_c;

  assign data_w[0]  = D;
  assign valid_w[0] = DV;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    ff_stage #(
      .WIDTH      (WIDTH),
      .RESET_VAL  (RESET_VAL),
      .SRMODE     (SRMODE),
      .CLEAR_DATA (CLEAR_DATA)
    ) u_stage (
      .clk_i (CK),
      .rst_i (CD),
      .ce_i  (SP),
      .sr_i  (SR),
      .d_i   (data_w[i]),
      .dv_i  (valid_w[i]),
      .q_o   (data_w[i+1]),
      .qv_o  (valid_w[i+1])
    );
  end

  assign clr_c = SR & (SP | (SRMODE == SRMODE_LSR_OVER_CE));

  // Occupancy follows the same priority as the stages so it equals the valid popcount.
  always_comb begin
    occ_d = occ_q;
    if (clr_c) begin
      occ_d = '0;
    end else if (SP) begin
      occ_d = occ_q + OW'(DV) - OW'(valid_w[DEPTH]);
    end
  end

  always_ff @(posedge CK) begin
    if (CD) occ_q <= '0;
    else    occ_q <= occ_d;
  end

  assign Q   = data_w[DEPTH];
  assign QV  = valid_w[DEPTH];
  assign OCC = occ_q;

endmodule

// File: tb/tb_ff_pipe_ce.sv
// Randomised and directed bench for ff_pipe_ce across three parameter sets.
module tb_ff_pipe_ce;

  logic       ck = 1'b0;
  logic       cd = 1'b0;
  logic       sp = 1'b0;
  logic       sr = 1'b0;
  logic [7:0] d  = 8'h00;
  logic       dv = 1'b0;

  logic [7:0] q_a, q_b, q_c;
  logic       qv_a, qv_b, qv_c;
  logic [1:0] occ_a, occ_b;
  logic       occ_c;

  int tests_run = 0;
  int tests_failed = 0;

  // Per-instance reference: depth, clear mode and data-clear flag.
  int unsigned dep [3] = '{3, 3, 1};
  bit          srm [3] = '{1'b0, 1'b1, 1'b0};
  bit          cld [3] = '{1'b1, 1'b0, 1'b1};
  logic [7:0]  md  [3][3];
  bit          mv  [3][3];

  always #5 ck = ~ck;

  ff_pipe_ce #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5), .SRMODE(0), .CLEAR_DATA(1'b1)) u_a (
    .CK(ck), .CD(cd), .SP(sp), .SR(sr), .D(d), .DV(dv), .Q(q_a), .QV(qv_a), .OCC(occ_a));
  ff_pipe_ce #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5), .SRMODE(1), .CLEAR_DATA(1'b0)) u_b (
    .CK(ck), .CD(cd), .SP(sp), .SR(sr), .D(d), .DV(dv), .Q(q_b), .QV(qv_b), .OCC(occ_b));
  ff_pipe_ce #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'hA5), .SRMODE(0), .CLEAR_DATA(1'b1)) u_c (
    .CK(ck), .CD(cd), .SP(sp), .SR(sr), .D(d), .DV(dv), .Q(q_c), .QV(qv_c), .OCC(occ_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference as a list of slots: newest at index 0, oldest at index dep-1.
  task automatic model_update();
    for (int n = 0; n < 3; n++) begin
      if (cd) begin
        for (int i = 0; i < 3; i++) begin
          md[n][i] = 8'hA5;
          mv[n][i] = 1'b0;
        end
      end else if (sr && (sp || srm[n])) begin
        for (int i = 0; i < 3; i++) begin
          mv[n][i] = 1'b0;
          if (cld[n]) md[n][i] = 8'hA5;
        end
      end else if (sp) begin
        for (int i = int'(dep[n]) - 1; i > 0; i--) begin
          md[n][i] = md[n][i-1];
          mv[n][i] = mv[n][i-1];
        end
        md[n][0] = d;
        mv[n][0] = dv;
      end
    end
  endtask

  function automatic int count_valid(input int n);
    int c = 0;
    for (int i = 0; i < int'(dep[n]); i++) c += int'(mv[n][i]);
    return c;
  endfunction

  task automatic check_models();
    check("a.Q",   32'(q_a),   32'(md[0][2]));
    check("a.QV",  32'(qv_a),  32'(mv[0][2]));
    check("a.OCC", 32'(occ_a), 32'(count_valid(0)));
    check("b.Q",   32'(q_b),   32'(md[1][2]));
    check("b.QV",  32'(qv_b),  32'(mv[1][2]));
    check("b.OCC", 32'(occ_b), 32'(count_valid(1)));
    check("c.Q",   32'(q_c),   32'(md[2][0]));
    check("c.QV",  32'(qv_c),  32'(mv[2][0]));
    check("c.OCC", 32'(occ_c), 32'(count_valid(2)));
  endtask

  task automatic step(input logic i_cd, input logic i_sp, input logic i_sr,
                      input logic [7:0] i_d, input logic i_dv);
    cd = i_cd; sp = i_sp; sr = i_sr; d = i_d; dv = i_dv;
    @(posedge ck);
    model_update();
    #1;
    check_models();
  endtask

  initial begin
    // Reset with enable high and data driven.
    step(1, 1, 0, 8'hFF, 1);
    step(1, 1, 0, 8'hFF, 1);
    check("rst.Q",   32'(q_a),   32'hA5);
    check("rst.QV",  32'(qv_a),  32'h0);
    check("rst.OCC", 32'(occ_a), 32'h0);
    step(1, 0, 1, 8'hFF, 1);
    check("rst2.Q",  32'(q_b),   32'hA5);

    // Stream 01..05 in; pipe fills and Q starts at 01 after the third edge.
    step(0, 1, 0, 8'h01, 1); check("s1.OCC", 32'(occ_a), 32'd1);
    step(0, 1, 0, 8'h02, 1); check("s2.OCC", 32'(occ_a), 32'd2);
    step(0, 1, 0, 8'h03, 1); check("s3.OCC", 32'(occ_a), 32'd3);
    check("s3.Q",  32'(q_a),  32'h01);
    check("s3.QV", 32'(qv_a), 32'h1);
    step(0, 1, 0, 8'h04, 1); check("s4.OCC", 32'(occ_a), 32'd3);
    check("s4.Q",  32'(q_a),  32'h02);

    // Stall: everything frozen.
    for (int k = 0; k < 4; k++) step(0, 0, 0, 8'hEE, 1);
    check("stall.Q",   32'(q_a),   32'h02);
    check("stall.OCC", 32'(occ_a), 32'd3);

    // Bubble then refill; QV drops for exactly one enabled cycle.
    step(0, 1, 0, 8'h05, 0);
    step(0, 1, 0, 8'h06, 1);
    check("bub1.QV", 32'(qv_a), 32'h1);
    step(0, 1, 0, 8'h07, 1);
    check("bub2.QV", 32'(qv_a), 32'h0);
    step(0, 1, 0, 8'h08, 1);
    check("bub3.QV", 32'(qv_a), 32'h1);

    // Refill from reset so Q=03 on a full pipe.
    step(1, 0, 0, 8'h00, 0);
    for (int k = 1; k <= 5; k++) step(0, 1, 0, 8'(k), 1);
    check("full.Q", 32'(q_b), 32'h03);

    // Clear without enable: only the LSR_OVER_CE instance reacts, data held.
    step(0, 0, 1, 8'h66, 1);
    check("ce0.Qa",   32'(q_a),   32'h03);
    check("ce0.OCCa", 32'(occ_a), 32'd3);
    check("ce0.Qb",   32'(q_b),   32'h03);
    check("ce0.QVb",  32'(qv_b),  32'h0);
    check("ce0.OCCb", 32'(occ_b), 32'd0);

    // Clear with enable: data-clearing instance loads A5, D is discarded.
    step(0, 1, 1, 8'h77, 1);
    check("clr.Qa",   32'(q_a),   32'hA5);
    check("clr.QVa",  32'(qv_a),  32'h0);
    check("clr.OCCa", 32'(occ_a), 32'd0);
    step(0, 1, 0, 8'h10, 1);
    step(0, 1, 0, 8'h11, 1);
    step(0, 1, 0, 8'h12, 1);
    check("disc.Qa", 32'(q_a), 32'h10);

    // Single-stage instance: one-edge latency, then reset overrides clear.
    step(0, 1, 0, 8'h5A, 1);
    check("d1.Q",   32'(q_c),   32'h5A);
    check("d1.QV",  32'(qv_c),  32'h1);
    check("d1.OCC", 32'(occ_c), 32'h1);
    step(1, 1, 1, 8'h33, 1);
    check("d1r.Q",  32'(q_c),  32'hA5);
    check("d1r.QV", 32'(qv_c), 32'h0);

    // Random traffic against the reference.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 11) == 0), 8'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
